reg_file: RTL and testbench



---
 rtl/reg_file.sv | 49 ++++
 tb/tb_reg_file.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one clocked write port.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              reg_write,
  output logic [WIDTH-1:0]  read_data1,
  output logic [WIDTH-1:0]  read_data2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;

  assign wr_en = reg_write && (write_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[write_reg] <= write_data;
    end
  end

  // Entry 0 is masked on read so it stays zero regardless of array state.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (!reset) begin
      if (read_reg1 != '0) read_data1 = mem[read_reg1];
      if (read_reg2 != '0) read_data2 = mem[read_reg2];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && (read_reg1 == write_reg)) read_data1 = write_data;
      if (wr_en && (read_reg2 == write_reg)) read_data2 = write_data;
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
// Same-cycle expectations follow REG_FILE_BYPASS_EN when it is defined.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic        reg_write = 1'b0;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int errors = 0;
  int checks = 0;

  reg_file dut (
    .clk        (clk),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if ($isunknown(reg_write)) begin
      errors++;
      $error("FAIL reg_write_unknown: got %b, want 0 or 1", reg_write);
    end
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    edge_step();
    reg_write  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    read_reg1 = a1;
    read_reg2 = a2;
    #1;
  endtask

  logic [31:0] exp1, exp2, pre_exp;

  initial begin
    edge_step();
    edge_step();
    rd(5'd7, 5'd3);
    chk("reset_rd1", read_data1, 32'h0);
    chk("reset_rd2", read_data2, 32'h0);

    reset = 1'b0;
    rd(5'd7, 5'd31);
    chk("post_reset_rd1", read_data1, 32'h0);
    chk("post_reset_rd2", read_data2, 32'h0);

    wr(5'd7, 32'hDEADBEEF);
    rd(5'd7, 5'd7);
    chk("wr7_rd1", read_data1, 32'hDEADBEEF);

    reset      = 1'b1;
    reg_write  = 1'b1;
    write_reg  = 5'd7;
    write_data = 32'h1;
    #1;
    chk("in_reset_rd1", read_data1, 32'h0);
    chk("in_reset_rd2", read_data2, 32'h0);
    edge_step();
    reset     = 1'b0;
    reg_write = 1'b0;
    #1;
    chk("reset_drop_wr7", read_data1, 32'h0);

    wr(5'd1, 32'h1);
    wr(5'd2, 32'h2);
    wr(5'd3, 32'h3);
    rd(5'd2, 5'd3);
    chk("basic_rd1_r2", read_data1, 32'h2);
    chk("basic_rd2_r3", read_data2, 32'h3);
    rd(5'd1, 5'd1);
    chk("same_r1_rd1", read_data1, 32'h1);
    chk("same_r1_rd2", read_data2, 32'h1);

    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    chk("zero_rd1", read_data1, 32'h0);
    chk("zero_rd2", read_data2, 32'h0);
    rd(5'd1, 5'd3);
    chk("zero_keep_r1", read_data1, 32'h1);
    chk("zero_keep_r3", read_data2, 32'h3);

    wr(5'd5, 32'hA);
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 32'hB;
    rd(5'd5, 5'd5);
`ifdef REG_FILE_BYPASS_EN
    pre_exp = 32'hB;
`else
    pre_exp = 32'hA;
`endif
    chk("rw_pre_rd1", read_data1, pre_exp);
    chk("rw_pre_rd2", read_data2, pre_exp);
    edge_step();
    reg_write = 1'b0;
    #1;
    chk("rw_post_rd1", read_data1, 32'hB);
    chk("rw_post_rd2", read_data2, 32'hB);

    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'h77;
    rd(5'd0, 5'd4);
    chk("no_bypass_r0", read_data1, 32'h0);
    reg_write = 1'b0;

    rd(5'd6, 5'd6);
    wr(5'd6, 32'h11);
    chk("b2b_first", read_data1, 32'h11);
    wr(5'd6, 32'h22);
    chk("b2b_second", read_data2, 32'h22);

    reg_write  = 1'b0;
    write_reg  = 5'd9;
    write_data = 32'h55;
    edge_step();
    rd(5'd9, 5'd9);
    chk("gate_r9", read_data1, 32'h0);

    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'h100 + 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      exp1 = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
      exp2 = (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i);
      chk($sformatf("sweep_p1_%0d", i), read_data1, exp1);
      chk($sformatf("sweep_p2_%0d", 31 - i), read_data2, exp2);
    end

    reset      = 1'b1;
    reg_write  = 1'b1;
    write_reg  = 5'd12;
    write_data = 32'hCAFE;
    edge_step();
    reset     = 1'b0;
    reg_write = 1'b0;
    rd(5'd12, 5'd31);
    chk("mid_reset_r12", read_data1, 32'h0);
    chk("mid_reset_r31", read_data2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
